// File: rtl/salida_cociente.sv
// salida_cociente: shifts one divider quotient bit per cycle into an N-bit register and flags completion.
// Ports: clk, reset (async, active-high), i_start (restart pulse), i_a (00 none, 10 bit0, 01 bit1, 11 illegal),
// q (quotient), o_count (bits accepted), o_busy (accumulating), o_done (q final), o_err (sticky protocol error).
module salida_cociente #(
  parameter int N = 8,
  parameter bit LSB_FIRST = 1'b0,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic [1:0]    i_a,
  output logic [N-1:0]  q,
  output logic [CW-1:0] o_count,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] q_n;
  logic [CW-1:0] count_n;
  logic err_n;
  logic valid, b;
  assign valid = i_a[1] ^ i_a[0];
  assign b = i_a == 2'b01;
  always_comb begin
    state_n = state;
    q_n = q;
    count_n = o_count;
    err_n = o_err;
    if (i_start) begin
      state_n = ACC;
      q_n = '0;
      count_n = '0;
      err_n = 1'b0;
    end else begin
      case (state)
        ACC: begin
          err_n = o_err | (i_a == 2'b11);
          if (valid) begin
            q_n = LSB_FIRST ? {b, q[N-1:1]} : {q[N-2:0], b};
            count_n = o_count + 1'b1;
            state_n = (count_n == CW'(N)) ? DONE : ACC;
          end
        end
        IDLE, DONE: err_n = o_err | (i_a != 2'b00);
        default: state_n = IDLE;
      endcase
    end
  end
  // busy/done are decoded from the next state so they stay registered, aligned with state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      q <= '0;
      o_count <= '0;
      o_err <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state <= state_n;
      q <= q_n;
      o_count <= count_n;
      o_err <= err_n;
      o_busy <= state_n == ACC;
      o_done <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_salida_cociente.sv
// tb_salida_cociente: checks three configurations (N=8 MSB-first, N=8 LSB-first, N=4) against a behavioural model.
module tb_salida_cociente;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] st = '0;
  logic [1:0] aa [3] = '{2'b00, 2'b00, 2'b00};
  logic [7:0] q8a, q8b;
  logic [3:0] q4;
  logic [3:0] c8a, c8b;
  logic [2:0] c4;
  logic [2:0] busy, done, err;
  int tests = 0;
  int fails = 0;
  int nw [3] = '{8, 8, 4};
  int lf [3] = '{0, 1, 0};
  int mq [3] = '{0, 0, 0};
  int mc [3] = '{0, 0, 0};
  int ms [3] = '{0, 0, 0};
  int me [3] = '{0, 0, 0};
  int dq [3], dc [3];

  always #5 clk = ~clk;

  salida_cociente #(.N(8), .LSB_FIRST(1'b0)) u0 (.clk(clk), .reset(reset), .i_start(st[0]), .i_a(aa[0]),
    .q(q8a), .o_count(c8a), .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0]));
  salida_cociente #(.N(8), .LSB_FIRST(1'b1)) u1 (.clk(clk), .reset(reset), .i_start(st[1]), .i_a(aa[1]),
    .q(q8b), .o_count(c8b), .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1]));
  salida_cociente #(.N(4), .LSB_FIRST(1'b0)) u2 (.clk(clk), .reset(reset), .i_start(st[2]), .i_a(aa[2]),
    .q(q4), .o_count(c4), .o_busy(busy[2]), .o_done(done[2]), .o_err(err[2]));

  always_comb begin
    dq[0] = int'(q8a);
    dq[1] = int'(q8b);
    dq[2] = int'(q4);
    dc[0] = int'(c8a);
    dc[1] = int'(c8b);
    dc[2] = int'(c4);
  end

  // Model: ms 0=idle 1=accumulating 2=done; q kept as an integer built from the accepted bits.
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        mq[i] = 0; mc[i] = 0; ms[i] = 0; me[i] = 0;
      end else if (st[i]) begin
        mq[i] = 0; mc[i] = 0; ms[i] = 1; me[i] = 0;
      end else if (ms[i] == 1 && aa[i] == 2'b11) begin
        me[i] = 1;
      end else if (ms[i] == 1 && aa[i] != 2'b00) begin
        if (lf[i] == 1)
          mq[i] = (mq[i] >> 1) + ((aa[i] == 2'b01) ? (1 << (nw[i] - 1)) : 0);
        else
          mq[i] = (mq[i] * 2 + ((aa[i] == 2'b01) ? 1 : 0)) % (1 << nw[i]);
        mc[i] = mc[i] + 1;
        if (mc[i] == nw[i]) ms[i] = 2;
      end else if (aa[i] != 2'b00) begin
        me[i] = 1;
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("q[%0d]", i), dq[i], mq[i]);
      chk($sformatf("count[%0d]", i), dc[i], mc[i]);
      chk($sformatf("busy[%0d]", i), int'(busy[i]), int'(ms[i] == 1));
      chk($sformatf("done[%0d]", i), int'(done[i]), int'(ms[i] == 2));
      chk($sformatf("err[%0d]", i), int'(err[i]), me[i]);
    end
  end

  task automatic step(input int i, input logic s, input logic [1:0] a);
    @(negedge clk);
    #1;
    st[i] = s;
    aa[i] = a;
    @(posedge clk);
    #1;
    st[i] = 1'b0;
    aa[i] = 2'b00;
  endtask

  task automatic bits(input int i, input logic [7:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) step(i, 1'b0, v[k] ? 2'b01 : 2'b10);
  endtask

  initial begin
    #1 reset = 1'b1;
    #20 reset = 1'b0;
    chk("reset q", int'(q8a), 0);
    chk("reset busy", int'(busy[0]), 0);
    // 1: MSB-first 10110010
    step(0, 1'b1, 2'b00);
    bits(0, 8'b10110010, 8);
    chk("s1 q", int'(q8a), 'hB2);
    chk("s1 count", int'(c8a), 8);
    chk("s1 done", int'(done[0]), 1);
    chk("s1 busy", int'(busy[0]), 0);
    chk("s1 err", int'(err[0]), 0);
    // 2: LSB-first same sequence
    step(1, 1'b1, 2'b00);
    bits(1, 8'b10110010, 8);
    chk("s2 q", int'(q8b), 'h4D);
    chk("s2 done", int'(done[1]), 1);
    // 3: idle cycle and illegal code mid-stream
    step(0, 1'b1, 2'b00);
    bits(0, 8'b11, 2);
    step(0, 1'b0, 2'b00);
    step(0, 1'b0, 2'b11);
    bits(0, 8'b01, 2);
    chk("s3 q", int'(q8a), 'h0D);
    chk("s3 count", int'(c8a), 4);
    chk("s3 busy", int'(busy[0]), 1);
    chk("s3 err", int'(err[0]), 1);
    // 4: overflow in DONE, then start with a simultaneous bit
    step(0, 1'b1, 2'b00);
    bits(0, 8'b10110010, 8);
    step(0, 1'b0, 2'b01);
    chk("s4 q held", int'(q8a), 'hB2);
    chk("s4 err", int'(err[0]), 1);
    step(0, 1'b1, 2'b01);
    chk("s4 restart q", int'(q8a), 0);
    chk("s4 restart count", int'(c8a), 0);
    chk("s4 restart err", int'(err[0]), 0);
    chk("s4 restart busy", int'(busy[0]), 1);
    // 5: async reset between edges
    step(0, 1'b1, 2'b00);
    bits(0, 8'b101, 3);
    #2 reset = 1'b1;
    #1;
    chk("s5 async q", int'(q8a), 0);
    chk("s5 async count", int'(c8a), 0);
    chk("s5 async busy", int'(busy[0]), 0);
    reset = 1'b0;
    step(0, 1'b1, 2'b00);
    bits(0, 8'b10, 2);
    chk("s5 clean q", int'(q8a), 2);
    chk("s5 clean count", int'(c8a), 2);
    // 6: N=4
    step(2, 1'b1, 2'b00);
    bits(2, 8'b1111, 3);
    chk("s6 not done early", int'(done[2]), 0);
    bits(2, 8'b1, 1);
    chk("s6 q", int'(q4), 'hF);
    chk("s6 done", int'(done[2]), 1);
    step(2, 1'b1, 2'b00);
    bits(2, 8'b0101, 4);
    chk("s6 q2", int'(q4), 'h5);
    chk("s6 done2", int'(done[2]), 1);
    // restart mid-accumulation is not an error
    step(1, 1'b1, 2'b00);
    bits(1, 8'b11, 2);
    step(1, 1'b1, 2'b00);
    chk("restart err", int'(err[1]), 0);
    chk("restart count", int'(c8b), 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
